// File: rtl/ahb_read_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : ahb_read_slave_param
// Purpose  : Parametrised AHB-Lite read-only register slave with OKAY and
//            two-cycle ERROR responses. Optional wait states: AHB_RD_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_read_slave_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 12,
    parameter int WAIT_W   = 4
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic                       hsel,
    input  logic [ADDR_W-1:0]          haddr,
    input  logic [1:0]                 htrans,
    input  logic                       hwrite,
    input  logic [2:0]                 hsize,
    input  logic                       hready,
    input  logic [NUM_REGS*DATA_W-1:0] rd_regs,
`ifdef AHB_RD_WAIT_EN
    input  logic [WAIT_W-1:0]          wait_cycles,
`endif
    output logic [DATA_W-1:0]          hrdata,
    output logic                       hreadyout,
    output logic                       hresp,
    output logic                       rd_strobe,
    output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] rd_index
);

    localparam int          RI_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int          LSB  = $clog2(DATA_W / 8);
    localparam int          IDX_W = ADDR_W - LSB;
    localparam logic [2:0]  LSB3 = 3'(LSB);

    if (WAIT_W < 1 || NUM_REGS < 1 || IDX_W < RI_W) begin : g_param_check
        $error("ahb_read_slave_param: illegal parameter combination");
    end

`ifdef AHB_RD_WAIT_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, WAIT = 3'd1, DATA = 3'd2, ERR1 = 3'd3, ERR2 = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, DATA = 3'd2, ERR1 = 3'd3, ERR2 = 3'd4
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_nx;
    logic [DATA_W-1:0]   regs_a [NUM_REGS];
    logic [IDX_W-1:0]    w_idx;
    logic [RI_W-1:0]     w_ri;
    logic                w_accept;
    logic                w_err;
    logic                w_zero_wait;
    logic                unused_htrans0;

    assign unused_htrans0 = htrans[0];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
        assign regs_a[gi] = rd_regs[gi*DATA_W +: DATA_W];
    end

    // Decode is done on the address phase and only its outcome is kept.
    assign w_idx    = haddr[ADDR_W-1:LSB];
    assign w_accept = hsel & hready & htrans[1];
    assign w_err    = hwrite
                    | (32'(w_idx) >= 32'(NUM_REGS))
                    | (hsize > LSB3)
                    | ((haddr & ~({ADDR_W{1'b1}} << hsize)) != '0);

`ifdef AHB_RD_WAIT_EN
    logic [WAIT_W-1:0]   r_cnt;
    logic [RI_W-1:0]     r_idx;

    assign w_zero_wait = (wait_cycles == '0);
    assign w_ri        = (r_state == WAIT) ? r_idx : w_idx[RI_W-1:0];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (hreadyout && w_accept) begin
            r_cnt <= wait_cycles;
            r_idx <= w_idx[RI_W-1:0];
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - WAIT_W'(1);
        end
    end
`else
    assign w_zero_wait = 1'b1;
    assign w_ri        = w_idx[RI_W-1:0];
`endif

    always_comb begin
        w_state_nx = r_state;
        hreadyout  = 1'b1;
        hresp      = 1'b0;
        case (r_state)
            IDLE: w_state_nx = IDLE;
`ifdef AHB_RD_WAIT_EN
            WAIT: begin
                hreadyout = 1'b0;
                if (r_cnt == WAIT_W'(1)) w_state_nx = DATA;
            end
`endif
            DATA: w_state_nx = IDLE;
            ERR1: begin
                hreadyout  = 1'b0;
                hresp      = 1'b1;
                w_state_nx = ERR2;
            end
            ERR2: begin
                hresp      = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
        // A new address phase is only sampled while the slave is ready.
        if (hreadyout && w_accept) begin
            if (w_err)            w_state_nx = ERR1;
            else if (w_zero_wait) w_state_nx = DATA;
`ifdef AHB_RD_WAIT_EN
            else                  w_state_nx = WAIT;
`endif
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state   <= IDLE;
            hrdata    <= '0;
            rd_strobe <= 1'b0;
            rd_index  <= '0;
        end else begin
            r_state   <= w_state_nx;
            rd_strobe <= (w_state_nx == DATA);
            if (w_state_nx == DATA) begin
                hrdata   <= regs_a[w_ri];
                rd_index <= w_ri;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_read_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_read_slave_param
// Purpose  : Randomised self-checking bench for ahb_read_slave_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_read_slave_param;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 12;
    localparam int WAIT_W   = 4;

    logic                       hclk = 1'b0;
    logic                       hreset;
    logic                       hsel;
    logic [ADDR_W-1:0]          haddr;
    logic [1:0]                 htrans;
    logic                       hwrite;
    logic [2:0]                 hsize;
    logic                       hready;
    logic [NUM_REGS*DATA_W-1:0] rd_regs;
`ifdef AHB_RD_WAIT_EN
    logic [WAIT_W-1:0]          wait_cycles;
`endif
    logic [DATA_W-1:0]          hrdata;
    logic                       hreadyout;
    logic                       hresp;
    logic                       rd_strobe;
    logic [2:0]                 rd_index;

    logic [DATA_W-1:0]          regs_m [NUM_REGS];
    logic [DATA_W-1:0]          last_data;
    int                         n_cmp = 0;
    int                         n_bad = 0;

    always #5 hclk = ~hclk;

    // This slave is alone on the bus, so the bus ready is its own ready.
    assign hready = hreadyout;

    always_comb begin
        rd_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) rd_regs[i*DATA_W +: DATA_W] = regs_m[i];
    end

    ahb_read_slave_param #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W)
    ) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hready(hready),
        .rd_regs(rd_regs),
`ifdef AHB_RD_WAIT_EN
        .wait_cycles(wait_cycles),
`endif
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
        .rd_strobe(rd_strobe), .rd_index(rd_index)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk_phase(input string tag, input logic rdy, input logic rsp, input logic stb);
        check({tag, ".hreadyout"}, 64'(hreadyout), 64'(rdy));
        check({tag, ".hresp"},     64'(hresp),     64'(rsp));
        check({tag, ".rd_strobe"}, 64'(rd_strobe), 64'(stb));
    endtask

    // Bus activity that must never be taken as a transfer.
    task automatic drive_idle();
        hsel   = 1'($urandom_range(0, 1));
        htrans = hsel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        haddr  = ADDR_W'($urandom);
        hwrite = 1'($urandom_range(0, 1));
        hsize  = 3'($urandom_range(0, 7));
`ifdef AHB_RD_WAIT_EN
        wait_cycles = WAIT_W'($urandom);
`endif
    endtask

    function automatic logic is_err(input int a, input logic wr, input int sz);
        return wr || (a / 4 >= NUM_REGS) || (sz > 2) || (a % (1 << sz) != 0);
    endfunction

    // One transfer: address phase, then every data-phase cycle checked.
    // Returns in the final data-phase cycle so a caller may pipeline.
    task automatic xfer(input int a, input logic wr, input int sz, input int w, input logic seq);
        int eff_w;
        int idx;
        hsel   = 1'b1;
        htrans = seq ? 2'b11 : 2'b10;
        haddr  = ADDR_W'(a);
        hwrite = wr;
        hsize  = 3'(sz);
`ifdef AHB_RD_WAIT_EN
        wait_cycles = WAIT_W'(w);
        eff_w = w;
`else
        eff_w = 0;
`endif
        idx = a / 4;
        step();
        drive_idle();
        if (is_err(a, wr, sz)) begin
            chk_phase("err1", 1'b0, 1'b1, 1'b0);
            step();
            chk_phase("err2", 1'b1, 1'b1, 1'b0);
            check("err2.hrdata", 64'(hrdata), 64'(last_data));
        end else begin
            for (int i = 0; i < eff_w; i++) begin
                chk_phase("wait", 1'b0, 1'b0, 1'b0);
                check("wait.hrdata", 64'(hrdata), 64'(last_data));
                if ($urandom_range(0, 2) == 0) regs_m[idx] = $urandom;
                step();
            end
            chk_phase("data", 1'b1, 1'b0, 1'b1);
            check("data.hrdata", 64'(hrdata), 64'(regs_m[idx]));
            check("data.rd_index", 64'(rd_index), 64'(idx));
            last_data = regs_m[idx];
        end
    endtask

    task automatic idle_cycle();
        step();
        chk_phase("idle", 1'b1, 1'b0, 1'b0);
        check("idle.hrdata", 64'(hrdata), 64'(last_data));
    endtask

    initial begin
        int a;
        int sz;
        logic wr;
        for (int i = 0; i < NUM_REGS; i++) regs_m[i] = $urandom;
        regs_m[2] = 32'hDEAD_BEEF;
        hreset = 1'b1;
        drive_idle();
        step();
        step();
        hreset = 1'b0;
        chk_phase("reset", 1'b1, 1'b0, 1'b0);
        check("reset.hrdata", 64'(hrdata), 64'd0);
        check("reset.rd_index", 64'(rd_index), 64'd0);
        last_data = '0;

        xfer(8, 1'b0, 2, 0, 1'b0);        idle_cycle();
        xfer('h40, 1'b0, 2, 0, 1'b0);     idle_cycle();
        xfer(0, 1'b1, 2, 0, 1'b0);        idle_cycle();
        xfer(2, 1'b0, 2, 0, 1'b0);        idle_cycle();
        xfer(4, 1'b0, 3, 0, 1'b0);        idle_cycle();
        xfer(0, 1'b0, 2, 0, 1'b0);
        xfer(4, 1'b0, 2, 0, 1'b1);
        xfer(8, 1'b0, 2, 0, 1'b1);        idle_cycle();
        xfer(28, 1'b0, 2, 0, 1'b0);
        xfer(32, 1'b0, 2, 0, 1'b1);
        xfer(13, 1'b0, 0, 0, 1'b0);       idle_cycle();

`ifdef AHB_RD_WAIT_EN
        xfer(4, 1'b0, 2, 3, 1'b0);        idle_cycle();
        // Reset during the second wait cycle drops the transfer silently.
        hsel = 1'b1; htrans = 2'b10; haddr = ADDR_W'(4); hwrite = 1'b0;
        hsize = 3'd2; wait_cycles = WAIT_W'(3);
        step();
        drive_idle();
        chk_phase("rst_wait1", 1'b0, 1'b0, 1'b0);
        step();
        chk_phase("rst_wait2", 1'b0, 1'b0, 1'b0);
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        chk_phase("rst_after", 1'b1, 1'b0, 1'b0);
        check("rst_after.hrdata", 64'(hrdata), 64'd0);
        last_data = '0;
        idle_cycle();
        idle_cycle();
`endif

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                a = int'($urandom_range(0, (1 << ADDR_W) - 1));
            end else begin
                a = int'($urandom_range(0, NUM_REGS + 1)) * 4;
                if ($urandom_range(0, 3) == 0) a += int'($urandom_range(0, 3));
            end
            sz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 2;
            wr = ($urandom_range(0, 7) == 0);
            xfer(a, wr, sz, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
                regs_m[$urandom_range(0, NUM_REGS - 1)] = $urandom;
                idle_cycle();
            end
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
